// File: rtl/ecc_sed_decoder.sv
// Single-error-detect (even parity) decoder with sticky status and a bad-run fault FSM.
// Define ECC_SED_DEC_CNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module ecc_sed_decoder #(
   parameter int FAULT_THRESH = 4,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enc_valid,
   input  logic [12:0]      enc_codeword,
   input  logic             err_clr,
   output logic             dec_valid,
   output logic [11:0]      dec_data,
   output logic             dec_err,
   output logic             err_sticky,
   output logic             fault,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [3:0] THRESH = 4'(FAULT_THRESH);

   typedef enum logic [1:0] {
      ST_OK,
      ST_SUSPECT,
      ST_FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  run_q, run_d;
   logic        dec_valid_q, dec_valid_d;
   logic [11:0] dec_data_q, dec_data_d;
   logic        dec_err_q, dec_err_d;
   logic        sticky_q, sticky_d;
   logic        accept;
   logic        syndrome;

   assign accept   = enc_valid && (state_q != ST_FAULT);
   assign syndrome = ^enc_codeword;

   always_comb begin
      dec_valid_d = 1'b0;
      dec_data_d  = dec_data_q;
      dec_err_d   = dec_err_q;
      sticky_d    = sticky_q;
      if (accept) begin
         dec_valid_d = 1'b1;
         dec_data_d  = enc_codeword[11:0];
         dec_err_d   = syndrome;
      end
      // A bad word in the clear cycle keeps the flag set.
      if (accept && syndrome) begin
         sticky_d = 1'b1;
      end else if (err_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (err_clr) begin
         state_d = ST_OK;
         run_d   = '0;
      end else begin
         case (state_q)
            ST_OK: begin
               if (accept && syndrome) begin
                  state_d = ST_SUSPECT;
                  run_d   = 4'd1;
               end
            end
            ST_SUSPECT: begin
               if (accept) begin
                  if (syndrome) begin
                     run_d = run_q + 4'd1;
                     if (run_q + 4'd1 == THRESH) begin
                        state_d = ST_FAULT;
                     end
                  end else begin
                     state_d = ST_OK;
                     run_d   = '0;
                  end
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_OK;
               run_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_OK;
         run_q       <= '0;
         dec_valid_q <= 1'b0;
         dec_data_q  <= '0;
         dec_err_q   <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         dec_valid_q <= dec_valid_d;
         dec_data_q  <= dec_data_d;
         dec_err_q   <= dec_err_d;
         sticky_q    <= sticky_d;
      end
   end

   assign dec_valid  = dec_valid_q;
   assign dec_data   = dec_data_q;
   assign dec_err    = dec_err_q;
   assign err_sticky = sticky_q;
   assign fault      = (state_q == ST_FAULT);

`ifdef ECC_SED_DEC_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept && syndrome) begin
         if (err_clr) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (err_clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign err_cnt = cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed scoreboard bench for ecc_sed_decoder; expected counts honour ECC_SED_DEC_CNT_EN.
module tb_ecc_sed_decoder;

`ifdef ECC_SED_DEC_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int THRESH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enc_valid = 1'b0;
   logic [12:0] enc_codeword = '0;
   logic        err_clr = 1'b0;
   logic        dec_valid;
   logic [11:0] dec_data;
   logic        dec_err;
   logic        err_sticky;
   logic        fault;
   logic [7:0]  err_cnt;

   logic        v2 = 1'b0;
   logic [12:0] cw2 = '0;
   logic        clr2 = 1'b0;
   logic        dv2;
   logic [11:0] dd2;
   logic        de2;
   logic        es2;
   logic        f2;
   logic [1:0]  cnt2;

   always #5 clk = ~clk;

   ecc_sed_decoder #(.FAULT_THRESH(THRESH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_codeword(enc_codeword),
      .err_clr(err_clr), .dec_valid(dec_valid), .dec_data(dec_data), .dec_err(dec_err),
      .err_sticky(err_sticky), .fault(fault), .err_cnt(err_cnt)
   );

   ecc_sed_decoder #(.FAULT_THRESH(THRESH), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .enc_valid(v2), .enc_codeword(cw2),
      .err_clr(clr2), .dec_valid(dv2), .dec_data(dd2), .dec_err(de2),
      .err_sticky(es2), .fault(f2), .err_cnt(cnt2)
   );

   typedef struct packed {
      logic        v;
      logic [11:0] d;
      logic        e;
      logic        s;
      logic        f;
      logic [7:0]  c;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic        m_dv, m_de, m_sticky, m_fault;
   logic [11:0] m_dd;
   int          m_run, m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dv = 0; m_dd = '0; m_de = 0; m_sticky = 0; m_fault = 0; m_run = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic v, input logic [12:0] cw, input logic clr, input int maxc);
      logic acc, bad;
      acc = v && !m_fault;
      bad = ^cw;
      m_dv = acc;
      if (acc) begin
         m_dd = cw[11:0];
         m_de = bad;
      end
      if (acc && bad) m_sticky = 1;
      else if (clr) m_sticky = 0;
      if (acc && bad) m_cnt = clr ? 1 : ((m_cnt < maxc) ? m_cnt + 1 : m_cnt);
      else if (clr) m_cnt = 0;
      if (clr) begin
         m_fault = 0;
         m_run = 0;
      end else if (acc) begin
         if (bad) begin
            m_run = m_run + 1;
            if (m_run == THRESH) m_fault = 1;
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic compare_outputs(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, "_valid"},  32'(dec_valid),  32'(e.v));
      check({tag, "_data"},   32'(dec_data),   32'(e.d));
      check({tag, "_err"},    32'(dec_err),    32'(e.e));
      check({tag, "_sticky"}, 32'(err_sticky), 32'(e.s));
      check({tag, "_fault"},  32'(fault),      32'(e.f));
      check({tag, "_cnt"},    32'(err_cnt),    32'(e.c));
   endtask

   task automatic step(input string tag, input logic v, input logic [12:0] cw, input logic clr);
      exp_t e;
      @(negedge clk);
      enc_valid = v;
      enc_codeword = cw;
      err_clr = clr;
      model_step(v, cw, clr, 255);
      e.v = m_dv; e.d = m_dd; e.e = m_de; e.s = m_sticky; e.f = m_fault;
      e.c = CNT_EN ? 8'(m_cnt) : 8'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      enc_valid = 1'b0;
      err_clr = 1'b0;
      compare_outputs(tag);
   endtask

   initial begin
      model_reset();
      #2;
      check("rst_valid",  32'(dec_valid),  0);
      check("rst_data",   32'(dec_data),   0);
      check("rst_err",    32'(dec_err),    0);
      check("rst_sticky", 32'(err_sticky), 0);
      check("rst_fault",  32'(fault),      0);
      check("rst_cnt",    32'(err_cnt),    0);
      @(negedge clk);
      rst = 1'b0;

      step("good_fff", 1'b1, 13'h0FFF, 1'b0);
      step("bad_001",  1'b1, 13'h0001, 1'b0);
      step("good_1001", 1'b1, 13'h1001, 1'b0);
      step("idle", 1'b0, 13'h0000, 1'b0);

      // Four consecutive bad words trip the fault; the fifth is dropped.
      for (int i = 0; i < 4; i++) step("run_bad", 1'b1, 13'h1FFF, 1'b0);
      step("fault_drop", 1'b1, 13'h1FFF, 1'b0);
      step("fault_clr", 1'b0, 13'h0000, 1'b1);

      // Clear coincident with a bad word in SUSPECT.
      step("sus_bad", 1'b1, 13'h0003 ^ 13'h0001, 1'b0);
      step("clr_bad", 1'b1, 13'h0001, 1'b1);
      for (int i = 0; i < 3; i++) step("after_clr_bad", 1'b1, 13'h1FFF, 1'b0);
      step("after_clr_good", 1'b1, 13'h0ABC ^ 13'h1000, 1'b0);

      // Idle cycles in SUSPECT keep the run.
      step("sus2_bad", 1'b1, 13'h0080, 1'b0);
      step("sus2_idle", 1'b0, 13'h0000, 1'b0);
      step("sus2_idle", 1'b0, 13'h0000, 1'b0);
      for (int i = 0; i < 3; i++) step("sus2_bad_run", 1'b1, 13'h0F0E, 1'b0);
      step("fault_clr_word", 1'b1, 13'h0001, 1'b1);
      step("post_clr_good", 1'b1, 13'h0555, 1'b0);
      step("clr_only", 1'b0, 13'h0000, 1'b1);
      step("bad_0400", 1'b1, 13'h0400, 1'b0);

      // Asynchronous reset mid-burst.
      @(negedge clk);
      enc_valid = 1'b1;
      enc_codeword = 13'h0F00;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("arst_valid",  32'(dec_valid),  0);
      check("arst_data",   32'(dec_data),   0);
      check("arst_err",    32'(dec_err),    0);
      check("arst_sticky", 32'(err_sticky), 0);
      check("arst_fault",  32'(fault),      0);
      check("arst_cnt",    32'(err_cnt),    0);
      @(negedge clk);
      enc_valid = 1'b0;
      rst = 1'b0;
      step("post_rst_bad", 1'b1, 13'h1234, 1'b0);
      step("post_rst_good", 1'b1, 13'h1FFE ^ 13'h0001 ^ 13'h1000, 1'b0);

      // Narrow counter saturation on the second instance.
      for (int i = 0; i < 5; i++) begin
         int exp_c;
         exp_c = CNT_EN ? ((i + 1 > 3) ? 3 : i + 1) : 0;
         @(negedge clk);
         v2 = 1'b1;
         cw2 = 13'h0001;
         @(posedge clk);
         #1;
         check("sat_cnt", 32'(cnt2), 32'(exp_c));
         check("sat_fault", 32'(f2), 0);
         @(negedge clk);
         cw2 = 13'h0000;
         @(posedge clk);
         #1;
         v2 = 1'b0;
         check("sat_good_err", 32'(de2), 0);
      end

      check("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ecc_sed_decoder.md
ECC_SED_DECODER -- requirements
Module: ecc_sed_decoder

Interface
REQ-001 SHALL have parameter FAULT_THRESH, default 4: consecutive bad codewords that trip FAULT (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of err_cnt.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port enc_valid  input  1  enc_codeword is valid this cycle.
REQ-006 SHALL have port enc_codeword  input  13  {parity, data[11:0]}; even parity over all 13 bits.
REQ-007 SHALL have port err_clr  input  1  one-cycle pulse; clears error status and fault.
REQ-008 SHALL have port dec_valid  output  1  dec_data/dec_err valid this cycle.
REQ-009 SHALL have port dec_data  output  12  decoded data, enc_codeword[11:0].
REQ-010 SHALL have port dec_err  output  1  parity check failed for the word on dec_data.
REQ-011 SHALL have port err_sticky  output  1  at least one bad word accepted since the last clear.
REQ-012 SHALL have port fault  output  1  FSM is in FAULT.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating count of bad words.

Function
REQ-014 Word accepted: enc_valid=1 and FSM not in FAULT; syndrome = XOR of all 13 codeword bits; 1 = error.
REQ-015 Latency exactly 1 cycle: on accept, dec_valid<=1, dec_data<=enc_codeword[11:0], dec_err<=syndrome.
REQ-016 No accept: dec_valid<=0; dec_data and dec_err hold their last values.
REQ-017 Data bits always pass through unmodified; no correction is attempted.
REQ-018 err_sticky set on accepted bad word, cleared by err_clr; both in the same cycle -> set wins.
REQ-019 err_cnt += 1 per accepted bad word; saturates at 2^CNT_W-1 (no wrap); err_clr zeroes it; clear and bad word in the same cycle -> 1.
REQ-020 FSM states OK, SUSPECT, FAULT; run counter tracks consecutive bad accepted words.
REQ-021 OK: bad word -> SUSPECT, run=1; good word -> stay.
REQ-022 SUSPECT: bad word -> run+1, and if run+1==FAULT_THRESH -> FAULT; good word -> OK, run=0; enc_valid=0 cycles leave state and run unchanged.
REQ-023 FAULT: fault=1; enc_valid words dropped (dec_valid=0, no count/sticky update); exit only via err_clr -> OK, run=0.
REQ-024 err_clr has priority over FSM transitions: next state OK, run=0 in every state; a word arriving in that cycle is still decoded and counted per REQ-018/019 unless the state was FAULT (then dropped).

Reset
REQ-025 rst=1 asynchronously forces dec_valid=0, dec_data=0, dec_err=0, err_sticky=0, fault=0, err_cnt=0, state OK, run=0.
REQ-026 Reset mid-stream discards any in-flight word; first word after rst deasserts is accepted normally on the next edge.

Configuration
REQ-027 Macro ECC_SED_DEC_CNT_EN defined: err_cnt implemented per REQ-019.
REQ-028 Macro undefined: no counter logic; err_cnt port remains and is tied to 0; all other behaviour unchanged.

Verification
REQ-029 enc_valid=1, enc_codeword=13'h0FFF -> next cycle dec_valid=1, dec_data=12'hFFF, dec_err=0, err_cnt=0.
REQ-030 codeword 13'h0001 then 13'h1001 -> dec_err=1 then 0; err_sticky=1; err_cnt=1; state returns to OK.
REQ-031 four consecutive 13'h1FFF (FAULT_THRESH=4) -> fault=1 after 4th; a 5th word yields dec_valid=0, err_cnt stays 4; err_clr pulse -> fault=0, err_cnt=0.
REQ-032 CNT_W=2, five bad words separated by good words -> err_cnt 1,2,3,3,3; fault never asserts.
REQ-033 err_clr coincident with bad word in SUSPECT -> err_sticky=1, err_cnt=1, state OK, run=0.
REQ-034 rst asserted asynchronously mid-burst -> all outputs 0 immediately; build without ECC_SED_DEC_CNT_EN -> err_cnt=0 throughout all above.
